// File: rtl/piso_tx.sv
// Parallel-in/serial-out transmitter with a one-word hold buffer.
// Streams WIDTH-bit words one bit per clock with sof/done frame strobes.
module piso_tx #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    output logic             din_ready,
    output logic             out,
    output logic             out_valid,
    output logic             sof,
    output logic             done
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    state_t state, state_n;

    logic [WIDTH-1:0] sh, sh_n;
    logic [WIDTH-1:0] hold, hold_n;
    logic [WIDTH-1:0] load_w;
    logic [CW-1:0]    cnt, cnt_n;
    logic             hold_full, hold_full_n;
    logic             out_n, out_valid_n;
    logic             sof_n, done_n;
    logic             accept, last, load;

    function automatic logic head(input logic [WIDTH-1:0] w);
        return MSB_FIRST ? w[WIDTH-1] : w[0];
    endfunction

    function automatic logic [WIDTH-1:0] adv(input logic [WIDTH-1:0] w);
        return MSB_FIRST ? (w << 1) : (w >> 1);
    endfunction

    assign accept = din_valid && din_ready;
    assign last   = (cnt == LAST);

    always_comb begin
        state_n     = state;
        sh_n        = sh;
        hold_n      = hold;
        hold_full_n = hold_full;
        cnt_n       = cnt;
        out_n       = 1'b0;
        out_valid_n = 1'b0;
        sof_n       = 1'b0;
        done_n      = 1'b0;
        load        = 1'b0;
        load_w      = din;

        unique case (state)
            IDLE: begin
                if (accept) begin
                    load    = 1'b1;
                    state_n = SHIFT;
                end
            end
            SHIFT: begin
                if (last) begin
                    // held word wins over din to keep strict FIFO order
                    if (hold_full) begin
                        load        = 1'b1;
                        load_w      = hold;
                        hold_full_n = 1'b0;
                    end else if (accept) begin
                        load = 1'b1;
                    end else begin
                        state_n = IDLE;
                    end
                end else begin
                    cnt_n       = cnt + 1'b1;
                    out_n       = head(sh);
                    sh_n        = adv(sh);
                    out_valid_n = 1'b1;
                    done_n      = (cnt_n == LAST);
                    if (accept) begin
                        hold_n      = din;
                        hold_full_n = 1'b1;
                    end
                end
            end
            default: state_n = IDLE;
        endcase

        if (load) begin
            cnt_n       = '0;
            out_n       = head(load_w);
            sh_n        = adv(load_w);
            out_valid_n = 1'b1;
            sof_n       = 1'b1;
            done_n      = (WIDTH == 1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            sh        <= '0;
            hold      <= '0;
            hold_full <= 1'b0;
            cnt       <= '0;
            out       <= 1'b0;
            out_valid <= 1'b0;
            sof       <= 1'b0;
            done      <= 1'b0;
            din_ready <= 1'b1;
        end else begin
            state     <= state_n;
            sh        <= sh_n;
            hold      <= hold_n;
            hold_full <= hold_full_n;
            cnt       <= cnt_n;
            out       <= out_n;
            out_valid <= out_valid_n;
            sof       <= sof_n;
            done      <= done_n;
            din_ready <= !hold_full_n;
        end
    end

endmodule

// File: tb/tb_piso_tx.sv
// Self-checking bench for piso_tx: MSB-first, LSB-first and 1-bit instances
// against a bit-queue reference model.
module tb_piso_tx;

    logic clk;
    logic rst;

    logic [7:0] d8;
    logic       v8, r8, o8, ov8, s8, dn8;
    logic [7:0] dl;
    logic       vl, rl, ol, ovl, sl, dnl;
    logic [0:0] d1;
    logic       v1, r1, o1, ov1, s1, dn1;

    int passed = 0;
    int total  = 0;

    // expected bits still to appear: {bit, sof, done}
    logic [2:0] q8[$];
    logic       eo, ev, es, ed, er, acc8;

    piso_tx u8 (
        .clk(clk), .rst(rst), .din(d8), .din_valid(v8),
        .din_ready(r8), .out(o8), .out_valid(ov8),
        .sof(s8), .done(dn8)
    );

    piso_tx #(.WIDTH(8), .MSB_FIRST(1'b0)) ul (
        .clk(clk), .rst(rst), .din(dl), .din_valid(vl),
        .din_ready(rl), .out(ol), .out_valid(ovl),
        .sof(sl), .done(dnl)
    );

    piso_tx #(.WIDTH(1), .MSB_FIRST(1'b1)) u1 (
        .clk(clk), .rst(rst), .din(d1), .din_valid(v1),
        .din_ready(r1), .out(o1), .out_valid(ov1),
        .sof(s1), .done(dn1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One cycle of the MSB-first model: expectations for the cycle seen
    // at this negedge, then drive inputs for the coming edge.
    task automatic tick8(input logic v, input logic [7:0] d);
        logic [2:0] f;
        @(negedge clk);
        er = (q8.size() <= 8);
        if (q8.size() > 0) begin
            f  = q8.pop_front();
            ev = 1'b1;
            eo = f[2];
            es = f[1];
            ed = f[0];
        end else begin
            {eo, ev, es, ed} = 4'b0000;
        end
        v8   = v;
        d8   = d;
        acc8 = v && er;
        if (acc8)
            for (int k = 0; k < 8; k++)
                q8.push_back({d[7-k], k == 0, k == 7});
    endtask

    task automatic test_reset();
        rst = 1'b1;
        {v8, vl, v1} = 3'b000;
        d8 = 8'h00; dl = 8'h00; d1 = 1'b0;
        @(negedge clk);
        total++;
        if ({o8, ov8, s8, dn8, r8} !== 5'b00001)
            $display("FAIL reset8 got %b want 00001", {o8, ov8, s8, dn8, r8});
        else passed++;
        total++;
        if ({ol, ovl, sl, dnl, rl} !== 5'b00001)
            $display("FAIL resetl got %b want 00001", {ol, ovl, sl, dnl, rl});
        else passed++;
        total++;
        if ({o1, ov1, s1, dn1, r1} !== 5'b00001)
            $display("FAIL reset1 got %b want 00001", {o1, ov1, s1, dn1, r1});
        else passed++;
        rst = 1'b0;
    endtask

    task automatic test_single();
        tick8(1'b1, 8'hA5);
        for (int i = 0; i < 11; i++) begin
            tick8(1'b0, 8'h00);
            total++;
            if ({o8, ov8, s8, dn8, r8} !== {eo, ev, es, ed, er})
                $display("FAIL single c%0d got %b want %b", i,
                         {o8, ov8, s8, dn8, r8}, {eo, ev, es, ed, er});
            else passed++;
        end
    endtask

    task automatic test_lsb();
        @(negedge clk);
        vl = 1'b1;
        dl = 8'h01;
        @(negedge clk);
        vl = 1'b0;
        dl = 8'hFF;
        for (int k = 0; k < 9; k++) begin
            logic [4:0] want;
            want = (k < 8) ? {k == 0, 1'b1, k == 0, k == 7, 1'b1} : 5'b00001;
            total++;
            if ({ol, ovl, sl, dnl, rl} !== want)
                $display("FAIL lsb b%0d got %b want %b", k,
                         {ol, ovl, sl, dnl, rl}, want);
            else passed++;
            @(negedge clk);
        end
    endtask

    task automatic test_width1();
        logic [2:0] w;
        w = 3'b101;
        @(negedge clk);
        v1 = 1'b1;
        d1 = w[2];
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            total++;
            if ({o1, ov1, s1, dn1, r1} !== {w[2-k], 4'b1111})
                $display("FAIL width1 b%0d got %b want %b", k,
                         {o1, ov1, s1, dn1, r1}, {w[2-k], 4'b1111});
            else passed++;
            if (k < 2) d1 = w[1-k];
            else v1 = 1'b0;
        end
        @(negedge clk);
        total++;
        if ({o1, ov1, s1, dn1, r1} !== 5'b00001)
            $display("FAIL width1 idle got %b want 00001", {o1, ov1, s1, dn1, r1});
        else passed++;
    endtask

    task automatic test_stream();
        logic [7:0] w[3];
        int idx, ones, rises;
        logic prev;
        w = '{8'hA5, 8'h3C, 8'hFF};
        idx = 0; ones = 0; rises = 0; prev = 1'b0;
        for (int i = 0; i < 32; i++) begin
            tick8(idx < 3, (idx < 3) ? w[idx] : 8'h00);
            total++;
            if ({o8, ov8, s8, dn8, r8} !== {eo, ev, es, ed, er})
                $display("FAIL stream c%0d got %b want %b", i,
                         {o8, ov8, s8, dn8, r8}, {eo, ev, es, ed, er});
            else passed++;
            if (ov8) ones++;
            if (ov8 && !prev) rises++;
            prev = ov8;
            if (acc8) idx++;
        end
        total++;
        if (ones != 24 || rises != 1)
            $display("FAIL stream_gapless got %0d bits %0d runs want 24 1",
                     ones, rises);
        else passed++;
    endtask

    task automatic test_done_accept();
        tick8(1'b1, 8'hC3);
        for (int i = 1; i < 12; i++) begin
            if (i == 8) tick8(1'b1, 8'h5A);
            else tick8(1'b0, 8'h00);
            total++;
            if ({o8, ov8, s8, dn8, r8} !== {eo, ev, es, ed, er})
                $display("FAIL done_accept c%0d got %b want %b", i,
                         {o8, ov8, s8, dn8, r8}, {eo, ev, es, ed, er});
            else passed++;
            if (i == 9) begin
                total++;
                if ({ov8, s8, r8} !== 3'b111)
                    $display("FAIL done_accept_nogap got %b want 111",
                             {ov8, s8, r8});
                else passed++;
            end
        end
        for (int i = 0; i < 8; i++) tick8(1'b0, 8'h00);
    endtask

    task automatic test_random();
        logic       pend;
        logic [7:0] pw;
        pend = 1'b0;
        pw   = 8'h00;
        for (int i = 0; i < 420; i++) begin
            if (i < 400 && !pend && $urandom_range(0, 2) != 0) begin
                pend = 1'b1;
                pw   = 8'($urandom);
            end
            tick8(pend, pend ? pw : 8'($urandom));
            total++;
            if ({o8, ov8, s8, dn8, r8} !== {eo, ev, es, ed, er})
                $display("FAIL random c%0d got %b want %b", i,
                         {o8, ov8, s8, dn8, r8}, {eo, ev, es, ed, er});
            else passed++;
            if (acc8) pend = 1'b0;
        end
    endtask

    task automatic test_reset_mid();
        tick8(1'b1, 8'hF0);
        for (int i = 0; i < 3; i++) begin
            tick8(1'b0, 8'h00);
            total++;
            if ({o8, ov8, s8, dn8, r8} !== {eo, ev, es, ed, er})
                $display("FAIL rstmid c%0d got %b want %b", i,
                         {o8, ov8, s8, dn8, r8}, {eo, ev, es, ed, er});
            else passed++;
        end
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        total++;
        if ({o8, ov8, s8, dn8} !== 4'b0000)
            $display("FAIL rstmid_async got %b want 0000", {o8, ov8, s8, dn8});
        else passed++;
        q8.delete();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 12; i++) begin
            tick8(1'b0, 8'h00);
            total++;
            if ({o8, ov8, s8, dn8, r8} !== 5'b00001)
                $display("FAIL rstmid_after c%0d got %b want 00001", i,
                         {o8, ov8, s8, dn8, r8});
            else passed++;
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_lsb();
        test_width1();
        test_stream();
        test_done_accept();
        test_random();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
